// File: rtl/seven_seg_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seven_seg_reader_if                                        |
// | Description : Bundle of the multiplexed seven-segment display bus and    |
// |               the readback results of seven_seg_reader.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Signals (names are from the reader's point of view):                     |
// |   sseg_c_i      [6:0]          cathodes, active-low, bit0=a .. bit6=g     |
// |   an_i          [DIGITS-1:0]   digit enables, active-low                  |
// |   clear_err_i                  clears the sticky error flag               |
// |   bcd_o         [4*DIGITS-1:0] captured code per digit, digit i at 4i+:4  |
// |   digit_valid_o [DIGITS-1:0]   digit captured at least once since reset   |
// |   capture_o                    one-cycle pulse per capture                |
// |   capture_idx_o [2:0]          digit index of the latest capture          |
// |   err_o                        sticky invalid-pattern flag                |
// |   frame_o                      one-cycle pulse per complete frame         |
// | Modports: master = display driver / bench, slave = the reader.           |
// +--------------------------------------------------------------------------+
interface seven_seg_reader_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          sseg_c_i;
  logic [DIGITS-1:0]   an_i;
  logic                clear_err_i;
  logic [4*DIGITS-1:0] bcd_o;
  logic [DIGITS-1:0]   digit_valid_o;
  logic                capture_o;
  logic [2:0]          capture_idx_o;
  logic                err_o;
  logic                frame_o;

  modport master (
    output sseg_c_i, an_i, clear_err_i,
    input  bcd_o, digit_valid_o, capture_o, capture_idx_o, err_o, frame_o
  );

  modport slave (
    input  sseg_c_i, an_i, clear_err_i,
    output bcd_o, digit_valid_o, capture_o, capture_idx_o, err_o, frame_o
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seven_seg_reader                                           |
// | Description : Watches a multiplexed, active-low seven-segment bus and    |
// |               turns every stable segment pattern back into a BCD code   |
// |               for the selected digit. Flags undecodable patterns and    |
// |               pulses once every digit has been captured.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters:                                                              |
// |   DIGITS        number of digit positions (1..8)                         |
// |   STABLE_CYCLES identical consecutive samples needed to capture (>= 2)  |
// | Ports:                                                                   |
// |   clk    rising-edge system clock                                        |
// |   reset  asynchronous, active-high                                       |
// |   bus    seven_seg_reader_if.slave (display bus in, readback results out)|
// +--------------------------------------------------------------------------+
module seven_seg_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  seven_seg_reader_if.slave      bus
);

  localparam int                  CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    C_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]    C_ONE    = CNT_W'(1);
  localparam logic [3:0]          C_BLANK  = 4'hF;
  localparam logic [3:0]          C_BAD    = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  // Pattern (g..a) to BCD. Blank is a legal "nothing shown" code.
  function automatic logic [3:0] f_decode(input logic [6:0] pat);
    logic [3:0] code;
    case (pat)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b1111111: code = C_BLANK;
      default:    code = C_BAD;
    endcase
    return code;
  endfunction

  // Input sample registers and their one-cycle-older copies
  logic [6:0]          sseg_q, prev_sseg_q;
  logic [DIGITS-1:0]   an_q, prev_an_q;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                capture_q;
  logic [2:0]          idx_q, idx_d;
  logic                err_q, err_d;
  logic                frame_q, frame_d;

  logic [DIGITS-1:0]   sel_mask;
  logic                sel_valid;
  logic [2:0]          sel_idx;
  logic                changed;
  logic                cap;
  logic [3:0]          code;

  // Selection decode: exactly one enable low, anything else is "no digit".
  always_comb begin
    sel_mask  = ~an_q;
    sel_valid = $onehot(sel_mask);
    sel_idx   = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_mask[i]) begin
        sel_idx = 3'(i);
      end
    end
    changed = (sseg_q != prev_sseg_q) || (an_q != prev_an_q);
    code    = f_decode(sseg_q);
  end

  // Stability FSM. The counter holds how many identical samples have been
  // seen; the capture fires on the edge that would bring it to STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sel_valid) begin
          state_d = S_SETTLE;
          cnt_d   = C_ONE;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          if (sel_valid) begin
            cnt_d = C_ONE;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q + C_ONE == C_STABLE) begin
          cap     = 1'b1;
          state_d = S_HELD;
          cnt_d   = C_STABLE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_HELD: begin
        if (changed) begin
          if (sel_valid) begin
            state_d = S_SETTLE;
            cnt_d   = C_ONE;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture datapath, frame tracking and sticky error.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    // A full mask is reported now and cleared on this same edge; a capture
    // landing here starts the next frame's mask.
    frame_d = &seen_q;
    seen_d  = frame_d ? '0 : seen_q;
    err_d   = bus.clear_err_i ? 1'b0 : err_q;
    if (cap) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_mask[i]) begin
          bcd_d[4*i +: 4] = code;
        end
      end
      valid_d = valid_q | sel_mask;
      seen_d  = seen_d | sel_mask;
      idx_d   = sel_idx;
      // Set wins over a coincident clear.
      if (code == C_BAD) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg_q      <= '1;
      an_q        <= '1;
      prev_sseg_q <= '1;
      prev_an_q   <= '1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bcd_q       <= '1;
      valid_q     <= '0;
      seen_q      <= '0;
      capture_q   <= 1'b0;
      idx_q       <= 3'd0;
      err_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      sseg_q      <= bus.sseg_c_i;
      an_q        <= bus.an_i;
      prev_sseg_q <= sseg_q;
      prev_an_q   <= an_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      capture_q   <= cap;
      idx_q       <= idx_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.bcd_o         = bcd_q;
  assign bus.digit_valid_o = valid_q;
  assign bus.capture_o     = capture_q;
  assign bus.capture_idx_o = idx_q;
  assign bus.err_o         = err_q;
  assign bus.frame_o       = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seven_seg_reader                                        |
// | Description : Self-checking bench for seven_seg_reader: directed steps   |
// |               followed by randomized bus traffic, all compared every     |
// |               cycle against a run-length reference model.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seven_seg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_seg_reader_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_reader #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int dut_caps = 0;
  int dut_frames = 0;

  // Segment patterns (g..a) for the digits 0..9
  logic [6:0] pat_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model state
  logic [4*DIGITS-1:0] m_bcd;
  logic [DIGITS-1:0]   m_valid, m_seen, m_last_an;
  logic [6:0]          m_last_sseg;
  logic                m_cap, m_err, m_frame;
  logic [2:0]          m_idx;
  int                  m_run;

  function automatic logic [3:0] ref_code(input logic [6:0] p);
    logic [3:0] c;
    c = 4'hE;
    if (p == 7'b1111111) c = 4'hF;
    for (int i = 0; i < 10; i++) if (p == pat_tbl[i]) c = 4'(i);
    return c;
  endfunction

  task automatic model_reset();
    m_bcd = '1; m_valid = '0; m_seen = '0; m_cap = 1'b0; m_err = 1'b0;
    m_frame = 1'b0; m_idx = 3'd0; m_last_sseg = '1; m_last_an = '1; m_run = 0;
  endtask

  // A capture happens on the edge after the sampled bus has shown the same
  // valid value for exactly STABLE consecutive edges.
  task automatic model_edge(input logic [6:0] s, input logic [DIGITS-1:0] a,
                            input logic clr);
    bit         cap;
    logic [3:0] code;
    cap  = (m_run == STABLE) && ($countones(~m_last_an) == 1);
    code = ref_code(m_last_sseg);
    m_frame = (m_seen == {DIGITS{1'b1}});
    if (m_frame) m_seen = '0;
    m_cap = cap;
    if (clr) m_err = 1'b0;
    if (cap) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!m_last_an[i]) begin
          m_bcd[4*i +: 4] = code;
          m_valid[i] = 1'b1;
          m_seen[i]  = 1'b1;
          m_idx      = 3'(i);
        end
      end
      if (code == 4'hE) m_err = 1'b1;
    end
    if (s == m_last_sseg && a == m_last_an) begin
      if (m_run <= STABLE) m_run = m_run + 1;
    end else begin
      m_run = 1;
    end
    m_last_sseg = s;
    m_last_an   = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bcd"},   32'(bus.bcd_o),         32'(m_bcd));
    chk({tag, ".valid"}, 32'(bus.digit_valid_o), 32'(m_valid));
    chk({tag, ".cap"},   32'(bus.capture_o),     32'(m_cap));
    chk({tag, ".idx"},   32'(bus.capture_idx_o), 32'(m_idx));
    chk({tag, ".err"},   32'(bus.err_o),         32'(m_err));
    chk({tag, ".frame"}, 32'(bus.frame_o),       32'(m_frame));
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(bus.sseg_c_i, bus.an_i, bus.clear_err_i);
      #1;
      check_all(tag);
      dut_caps   += int'(bus.capture_o);
      dut_frames += int'(bus.frame_o);
    end
  endtask

  task automatic drive(input logic [DIGITS-1:0] a, input logic [6:0] s, input logic clr);
    bus.an_i = a; bus.sseg_c_i = s; bus.clear_err_i = clr;
  endtask

  function automatic logic [DIGITS-1:0] an_for(input int d);
    logic [DIGITS-1:0] v;
    v = '1;
    v[d] = 1'b0;
    return v;
  endfunction

  initial begin
    int caps0, frames0;
    int digs [4] = '{1, 2, 5, 9};
    logic [DIGITS-1:0] a;
    logic [6:0] s;
    logic clr;

    model_reset();
    drive('1, '1, 1'b0);
    step(2, "reset");
    reset = 1'b0;

    // Idle bus
    step(20, "idle");
    chk("idle_no_caps", 32'(dut_caps), 32'd0);
    chk("idle_bcd", 32'(bus.bcd_o), 32'h0000FFFF);

    // Digit 0 shows 3: capture on the fifth edge counting the first sample
    drive(4'b1110, 7'b0110000, 1'b0);
    step(4, "d0");
    chk("d0_early", 32'(bus.capture_o), 32'd0);
    step(1, "d0");
    chk("d0_cap", 32'(bus.capture_o), 32'd1);
    chk("d0_nib", 32'(bus.bcd_o[3:0]), 32'h3);
    chk("d0_idx", 32'(bus.capture_idx_o), 32'd0);
    chk("d0_valid", 32'(bus.digit_valid_o), 32'b0001);

    // Scan 1,2,5,9 over digits 0..3
    caps0 = dut_caps; frames0 = dut_frames;
    for (int d = 0; d < 4; d++) begin
      drive(an_for(d), pat_tbl[digs[d]], 1'b0);
      step(6, "scan");
    end
    chk("scan_caps", 32'(dut_caps - caps0), 32'd4);
    chk("scan_bcd", 32'(bus.bcd_o), 32'h9521);
    chk("scan_frames", 32'(dut_frames - frames0), 32'd1);

    // Short 6 glitch followed by a stable 7 on digit 1
    caps0 = dut_caps;
    drive(4'b1101, 7'b0000010, 1'b0);
    step(3, "glitch6");
    drive(4'b1101, 7'b1111000, 1'b0);
    step(5, "hold7");
    chk("glitch_caps", 32'(dut_caps - caps0), 32'd1);
    chk("glitch_nib", 32'(bus.bcd_o[7:4]), 32'h7);

    // Invalid pattern on digit 2, sticky error, clear, coincident set/clear
    drive(4'b1011, 7'b0101010, 1'b0);
    step(4, "bad");
    drive(4'b1011, 7'b1111111, 1'b0);
    step(2, "bad");
    chk("bad_nib", 32'(bus.bcd_o[11:8]), 32'hE);
    chk("bad_err", 32'(bus.err_o), 32'd1);
    step(4, "blank");
    chk("err_sticky", 32'(bus.err_o), 32'd1);
    drive(4'b1011, 7'b1111111, 1'b1);
    step(1, "clr");
    drive(4'b1011, 7'b1111111, 1'b0);
    chk("err_cleared", 32'(bus.err_o), 32'd0);
    drive(4'b1011, 7'b0101011, 1'b0);
    step(4, "bad2");
    drive(4'b1011, 7'b0101011, 1'b1);
    step(1, "bad2");
    drive(4'b1011, 7'b0101011, 1'b0);
    chk("setwins_cap", 32'(bus.capture_o), 32'd1);
    chk("setwins_err", 32'(bus.err_o), 32'd1);

    // Reset two cycles into SETTLE on digit 1
    drive(4'b1101, 7'b0011001, 1'b0);
    step(3, "pre_rst");
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    step(2, "in_rst");
    reset = 1'b0;
    step(4, "post_rst");
    chk("rst_early", 32'(bus.capture_o), 32'd0);
    step(1, "post_rst");
    chk("rst_cap", 32'(bus.capture_o), 32'd1);
    chk("rst_nib", 32'(bus.bcd_o[7:4]), 32'h4);
    chk("rst_valid", 32'(bus.digit_valid_o), 32'b0010);

    // Randomized traffic
    for (int seg = 0; seg < 70; seg++) begin
      if ($urandom_range(0, 9) < 8) a = an_for(int'($urandom_range(0, DIGITS - 1)));
      else a = DIGITS'($urandom);
      case ($urandom_range(0, 9))
        0:       s = 7'b1111111;
        1, 2:    s = 7'($urandom);
        default: s = pat_tbl[$urandom_range(0, 9)];
      endcase
      clr = ($urandom_range(0, 7) == 0);
      drive(a, s, clr);
      step(1, "rand");
      drive(a, s, 1'b0);
      step(int'($urandom_range(0, 6)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
